// File: rtl/fp8_pkg.sv
// fp8_pkg: shared definitions for the 8-bit minifloat datapath
// (1 sign, 4 exponent, 3 fraction, bias 7).
// Contents: format constants, fp8 field struct, accumulator FSM state
// enum, and a helper that decodes a minifloat to an unsigned
// fixed-point magnitude with LSB weight 2^-10.
package fp8_pkg;

  localparam int BIT_WIDTH      = 8;
  localparam int EXP_WIDTH      = 4;
  localparam int MANTISSA_WIDTH = 3;
  localparam int BIAS           = 7;
  localparam int EXP_MAX        = 15;
  localparam int EXP_MIN        = 0;

  // Largest decoded magnitude is 15 << 15, which fits in 19 bits.
  localparam int MAG_W = (MANTISSA_WIDTH + 1) + EXP_MAX;

  typedef struct packed {
    logic                      sign;
    logic [EXP_WIDTH-1:0]      exp;
    logic [MANTISSA_WIDTH-1:0] frac;
  } fp8_t;

  typedef enum logic [1:0] {
    ST_ACCUM   = 2'd0,
    ST_CONVERT = 2'd1,
    ST_HOLD    = 2'd2
  } accum_state_t;

  // Exponent 0 keeps hidden bit 0 and no exponent adjust, matching the
  // multiplier's output semantics; the result is sig << exp.
  function automatic logic [MAG_W-1:0] fp8_mag(input fp8_t d);
    logic [MANTISSA_WIDTH:0] sig;
    sig = {(d.exp != '0), d.frac};
    return MAG_W'(sig) << d.exp;
  endfunction

endpackage

// File: rtl/fp8_encode.sv
// fp8_encode: combinational conversion of a signed fixed-point sum
// (LSB weight 2^-10) to one 8-bit minifloat, truncating toward zero.
// Ports:
//   i_acc      in   ACC_W  signed accumulator value
//   o_data     out  8      minifloat result (zero is always 0x00)
//   o_ovf      out  1      magnitude too large, result saturated
//   o_inexact  out  1      nonzero bits were discarded
module fp8_encode
  import fp8_pkg::*;
#(
  parameter int ACC_W = 24
) (
  input  logic signed [ACC_W-1:0] i_acc,
  output logic [BIT_WIDTH-1:0]    o_data,
  output logic                    o_ovf,
  output logic                    o_inexact
);

  localparam int P_W = $clog2(ACC_W);
  localparam logic [ACC_W-1:0] ONE = ACC_W'(1);
  // Leading-one position at which the exponent field would exceed EXP_MAX.
  localparam int SAT_P = EXP_MAX + MANTISSA_WIDTH + 1;

  logic             w_neg;
  logic [ACC_W-1:0] w_mag;
  logic [P_W-1:0]   w_p;
  logic             w_nz;
  logic [P_W-1:0]   w_shamt;
  logic [ACC_W-1:0] w_mask;

  assign w_neg = i_acc[ACC_W-1];
  assign w_mag = w_neg ? (~i_acc + ONE) : i_acc;

  // Leading-one detector: the highest set bit wins.
  always_comb begin
    w_p  = '0;
    w_nz = 1'b0;
    for (int i = 0; i < ACC_W; i++) begin
      if (w_mag[i]) begin
        w_p  = P_W'(i);
        w_nz = 1'b1;
      end
    end
  end

  // For a normal result the exponent field equals the number of bits
  // shifted out below the 3-bit fraction.
  assign w_shamt = w_p - P_W'(3);
  assign w_mask  = (ONE << w_shamt) - ONE;

  always_comb begin
    o_data    = '0;
    o_ovf     = 1'b0;
    o_inexact = 1'b0;
    if (!w_nz) begin
      o_data = '0;
    end else if (w_p <= P_W'(2)) begin
      o_data = {w_neg, 4'd0, w_mag[2:0]};
    end else if (w_p == P_W'(3)) begin
      // 8..15 has no encoding (exp 1 starts at 16); clamp to largest exp-0 value.
      o_data    = {w_neg, 4'd0, 3'd7};
      o_inexact = 1'b1;
    end else if (w_p < P_W'(SAT_P)) begin
      o_data    = {w_neg, w_shamt[EXP_WIDTH-1:0], w_mag[w_shamt +: MANTISSA_WIDTH]};
      o_inexact = |(w_mag & w_mask);
    end else begin
      o_data    = {w_neg, 4'(EXP_MAX), 3'd7};
      o_ovf     = 1'b1;
      o_inexact = 1'b1;
    end
  end

endmodule

// File: rtl/fp8_accum.sv
// fp8_accum: streaming sum-reduction of minifloat products.
// Accepts a group of up to MAX_TERMS products on a valid/ready port, sums
// them exactly in a signed fixed-point accumulator, converts the total to
// one minifloat and presents it on a valid/ready output port.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   in_valid/in_ready/in_data        product beat handshake and data
//   in_ovf/in_unf                    multiplier flags for the beat
//   in_last                          final beat of the group
//   out_valid/out_ready/out_data     result handshake and data
//   out_ovf/out_unf/out_inexact      result flags
//   out_count                        number of beats in the group
module fp8_accum
  import fp8_pkg::*;
#(
  parameter int MAX_TERMS = 16,
  parameter int ACC_W     = 20 + $clog2(MAX_TERMS),
  parameter int CNT_W     = $clog2(MAX_TERMS + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BIT_WIDTH-1:0] in_data,
  input  logic                 in_ovf,
  input  logic                 in_unf,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BIT_WIDTH-1:0] out_data,
  output logic                 out_ovf,
  output logic                 out_unf,
  output logic                 out_inexact,
  output logic [CNT_W-1:0]     out_count
);

  accum_state_t r_state, w_state_next;

  logic signed [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_ovf_sticky;
  logic                    r_unf_sticky;
  logic                    r_out_valid;
  logic [BIT_WIDTH-1:0]    r_out_data;
  logic                    r_out_ovf;
  logic                    r_out_unf;
  logic                    r_out_inexact;
  logic [CNT_W-1:0]        r_out_count;

  logic [MAG_W-1:0]        w_mag;
  logic signed [ACC_W-1:0] w_term;
  logic                    w_accept;
  logic                    w_cnt_full;
  logic                    w_handshake;
  logic [BIT_WIDTH-1:0]    w_enc_data;
  logic                    w_enc_ovf;
  logic                    w_enc_inexact;

  // Decode: 0x00 and 0x80 both give magnitude 0, so negation is harmless.
  assign w_mag  = fp8_mag(fp8_t'(in_data));
  assign w_term = in_data[BIT_WIDTH-1] ? -$signed(ACC_W'(w_mag)) : $signed(ACC_W'(w_mag));

  assign in_ready    = (r_state == ST_ACCUM);
  assign w_accept    = in_valid && in_ready;
  // The MAX_TERMS-th beat closes the group even without in_last.
  assign w_cnt_full  = (r_cnt + CNT_W'(1)) == CNT_W'(MAX_TERMS);
  assign w_handshake = r_out_valid && out_ready;

  fp8_encode #(.ACC_W(ACC_W)) u_encode (
    .i_acc     (r_acc),
    .o_data    (w_enc_data),
    .o_ovf     (w_enc_ovf),
    .o_inexact (w_enc_inexact)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_ACCUM;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_ACCUM:   if (w_accept && (in_last || w_cnt_full)) w_state_next = ST_CONVERT;
      ST_CONVERT: w_state_next = ST_HOLD;
      ST_HOLD:    if (w_handshake) w_state_next = ST_ACCUM;
      default:    w_state_next = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc         <= '0;
      r_cnt         <= '0;
      r_ovf_sticky  <= 1'b0;
      r_unf_sticky  <= 1'b0;
      r_out_valid   <= 1'b0;
      r_out_data    <= '0;
      r_out_ovf     <= 1'b0;
      r_out_unf     <= 1'b0;
      r_out_inexact <= 1'b0;
      r_out_count   <= '0;
    end else begin
      if (w_accept) begin
        r_acc        <= r_acc + w_term;
        r_cnt        <= r_cnt + CNT_W'(1);
        r_ovf_sticky <= r_ovf_sticky | in_ovf;
        r_unf_sticky <= r_unf_sticky | in_unf;
      end
      if (r_state == ST_CONVERT) begin
        r_out_valid   <= 1'b1;
        r_out_data    <= w_enc_data;
        r_out_ovf     <= w_enc_ovf | r_ovf_sticky;
        r_out_unf     <= r_unf_sticky;
        r_out_inexact <= w_enc_inexact;
        r_out_count   <= r_cnt;
      end
      // Result fields stay as last presented; only valid drops.
      if (r_state == ST_HOLD && w_handshake) begin
        r_acc        <= '0;
        r_cnt        <= '0;
        r_ovf_sticky <= 1'b0;
        r_unf_sticky <= 1'b0;
        r_out_valid  <= 1'b0;
      end
    end
  end

  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign out_ovf     = r_out_ovf;
  assign out_unf     = r_out_unf;
  assign out_inexact = r_out_inexact;
  assign out_count   = r_out_count;

endmodule

// File: tb/tb_fp8_accum.sv
// tb_fp8_accum: directed self-checking bench for fp8_accum.
module tb_fp8_accum;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_ovf;
  logic       in_unf;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_ovf;
  logic       out_unf;
  logic       out_inexact;
  logic [4:0] out_count;

  int checks;
  int failures;

  fp8_accum dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_ovf      (in_ovf),
    .in_unf      (in_unf),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_ovf     (out_ovf),
    .out_unf     (out_unf),
    .out_inexact (out_inexact),
    .out_count   (out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the beat is accepted.
  task automatic send(input logic [7:0] d, input logic l, input logic o, input logic u);
    int n;
    in_data  = d;
    in_last  = l;
    in_ovf   = o;
    in_unf   = u;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("send_timeout", 32'd0, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_ovf   = 1'b0;
    in_unf   = 1'b0;
  endtask

  task automatic get_result(input string tag, input logic [7:0] d, input logic o,
                            input logic u, input logic x, input logic [4:0] c);
    int n;
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check({tag, "_timeout"}, 32'd0, 32'd1);
    $display("group %s: data=%02h ovf=%0d unf=%0d inexact=%0d count=%0d",
             tag, out_data, out_ovf, out_unf, out_inexact, out_count);
    check({tag, "_data"},    32'(out_data),    32'(d));
    check({tag, "_ovf"},     32'(out_ovf),     32'(o));
    check({tag, "_unf"},     32'(out_unf),     32'(u));
    check({tag, "_inexact"}, 32'(out_inexact), 32'(x));
    check({tag, "_count"},   32'(out_count),   32'(c));
    if (out_ready) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  32'(in_ready),    32'd1);
    check({tag, "_out_valid"}, 32'(out_valid),   32'd0);
    check({tag, "_data"},      32'(out_data),    32'h00);
    check({tag, "_ovf"},       32'(out_ovf),     32'd0);
    check({tag, "_unf"},       32'(out_unf),     32'd0);
    check({tag, "_inexact"},   32'(out_inexact), 32'd0);
    check({tag, "_count"},     32'(out_count),   32'd0);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_ovf    = 1'b0;
    in_unf    = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // 1.0 + 1.0 = 2.0
    send(8'h38, 1'b0, 1'b0, 1'b0);
    send(8'h38, 1'b1, 1'b0, 1'b0);
    get_result("two_plus", 8'h40, 1'b0, 1'b0, 1'b0, 5'd2);

    // 1.0 - 1.0 = 0
    send(8'h38, 1'b0, 1'b0, 1'b0);
    send(8'hB8, 1'b1, 1'b0, 1'b0);
    get_result("cancel", 8'h00, 1'b0, 1'b0, 1'b0, 5'd2);

    // 1.125 + 2^-10: low bit lost
    send(8'h39, 1'b0, 1'b0, 1'b0);
    send(8'h01, 1'b1, 1'b0, 1'b0);
    get_result("trunc", 8'h39, 1'b0, 1'b0, 1'b1, 5'd2);

    // 4+4 = 8 ulp, the unrepresentable gap
    send(8'h04, 1'b0, 1'b0, 1'b0);
    send(8'h04, 1'b1, 1'b0, 1'b0);
    get_result("gap", 8'h07, 1'b0, 1'b0, 1'b1, 5'd2);

    // saturation, both signs
    send(8'h7F, 1'b0, 1'b0, 1'b0);
    send(8'h7F, 1'b1, 1'b0, 1'b0);
    get_result("sat_pos", 8'h7F, 1'b1, 1'b0, 1'b1, 5'd2);
    send(8'hFF, 1'b0, 1'b0, 1'b0);
    send(8'hFF, 1'b1, 1'b0, 1'b0);
    get_result("sat_neg", 8'hFF, 1'b1, 1'b0, 1'b1, 5'd2);

    // sticky flags
    send(8'h38, 1'b0, 1'b0, 1'b1);
    send(8'h38, 1'b1, 1'b0, 1'b0);
    get_result("unf_sticky", 8'h40, 1'b0, 1'b1, 1'b0, 5'd2);
    send(8'h38, 1'b0, 1'b1, 1'b0);
    send(8'h38, 1'b1, 1'b0, 1'b0);
    get_result("ovf_sticky", 8'h40, 1'b1, 1'b0, 1'b0, 5'd2);

    // 16 beats without in_last close the group implicitly
    for (int i = 0; i < 16; i++) send(8'h38, 1'b0, 1'b0, 1'b0);
    check("full_convert_in_ready", 32'(in_ready), 32'd0);
    check("full_convert_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("full_latency_valid", 32'(out_valid), 32'd1);
    get_result("full16", 8'h58, 1'b0, 1'b0, 1'b0, 5'd16);

    // backpressure: outputs frozen, input port closed
    out_ready = 1'b0;
    send(8'h38, 1'b0, 1'b0, 1'b0);
    send(8'h38, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_data", 32'(out_data), 32'h40);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    check("bp_release_valid", 32'(out_valid), 32'd0);
    send(8'h38, 1'b1, 1'b0, 1'b0);
    get_result("after_bp", 8'h38, 1'b0, 1'b0, 1'b0, 5'd1);

    // reset mid-group aborts it
    for (int i = 0; i < 3; i++) send(8'h38, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(8'h38, 1'b1, 1'b0, 1'b0);
    get_result("post_reset", 8'h38, 1'b0, 1'b0, 1'b0, 5'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp8_accum.md
# fp8_accum

- Streaming sum-reduction stage directly downstream of the 4-stage 8-bit minifloat multiplier (1 sign, 4 exp, 3 frac, bias 7).
- Consumes a group of products over a valid/ready input port and adds them exactly in a wide signed fixed-point accumulator.
- Converts the total back to one 8-bit minifloat with truncation and sticky flags.
- Emits the result over a valid/ready output port. Used as the dot-product tail of the multiply path.

## Interface
- MAX_TERMS, 16, maximum products per group; power of two, ≥2.
- ACC_W, 20+$clog2(MAX_TERMS), signed accumulator width (24 at default).
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  product beat valid.
- in_ready  out  1  block accepts a beat.
- in_data  in  8  minifloat product.
- in_ovf  in  1  multiplier overflow flag aligned with in_data.
- in_unf  in  1  multiplier underflow flag aligned with in_data.
- in_last  in  1  final beat of the group.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  8  minifloat sum.
- out_ovf  out  1  result saturated, or any in_ovf seen in the group.
- out_unf  out  1  any in_unf seen in the group.
- out_inexact  out  1  nonzero bits discarded during encode.
- out_count  out  $clog2(MAX_TERMS+1)  beats in the group.

## Operation
- **Decode.** Field split is s=in_data[7], e=in_data[6:3], f=in_data[2:0].
  - sig = {e!=0, f}; magnitude = sig << e, with LSB weight 2^-10. This matches the multiplier's exp-0 semantics (hidden bit 0, no exponent adjust).
  - Term is the magnitude negated when s=1. 0x00 and 0x80 both decode to 0.
- **Accumulation.** Every term is < 2^19, so acc cannot wrap within MAX_TERMS beats. The add is exact.
- **States.**
  - ACCUM: in_ready=1. Each accepted beat does acc += term, cnt += 1, and ORs in_ovf/in_unf into sticky flags.
    - Go to CONVERT when the beat has in_last=1.
    - Also go to CONVERT when cnt reaches MAX_TERMS; that beat is treated as an implicit last.
  - CONVERT: one cycle, in_ready=0. Computes mag=|acc| and p = index of the leading one of mag. Registers the result fields and sets out_valid. Next state HOLD.
  - HOLD: in_ready=0; outputs stable. On out_valid && out_ready: clear acc, cnt and sticky flags, drop out_valid, go to ACCUM.
- **Encode** (result sign = acc<0; a zero result is always 0x00).
  - mag=0: 0x00.
  - p≤2: exp=0, frac=mag[2:0], exact.
  - p=3 (mag 8..15), which is unrepresentable: truncate to 0x07 magnitude, inexact=1.
  - 4≤p≤18: exp=p-3, frac=mag[p-1:p-3]; inexact=|mag[p-4:0].
  - p≥19: saturate to exp=15, frac=7, out_ovf=1, inexact=1.
- **Reset.** rst_n low at any time aborts the group: state ACCUM, acc=0, cnt=0, flags cleared.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=0x00, out_ovf=0, out_unf=0, out_inexact=0, out_count=0.
- Latency: last beat accepted at edge k gives CONVERT in cycle k..k+1 and out_valid=1 after edge k+1.
- in_ready is combinational from state only, never from in_valid or out_ready.
- out_ready may be held low indefinitely. Outputs stay frozen and in_ready stays 0.
- A beat presented during CONVERT or HOLD is not accepted and must be held by the producer.
- in_ready returns to 1 the cycle after the output handshake. Minimum group period is N+2 cycles.
- in_valid with in_last on the first beat gives a 1-term group (out_count=1).

## Structure
- Shared package fp8_pkg holds BIT_WIDTH=8, EXP_WIDTH=4, MANTISSA_WIDTH=3, BIAS=7, EXP_MAX=15, EXP_MIN=0, plus the fp8 sign/exp/frac struct typedef. The multiplier uses the same package.
- Combinational sub-module fp8_encode takes the signed acc and returns data, ovf and inexact.
- The main module holds the FSM, accumulator, counter and sticky flags.

## Test plan
- 0x38, 0x38(last) → 0x40, count=2, all flags 0. Then 0x38, 0xB8(last) → 0x00, count=2, all flags 0.
- 0x39, 0x01(last) → 0x39, inexact=1. 0x04, 0x04(last) → 0x07, inexact=1.
- 0x7F, 0x7F(last) → 0x7F, ovf=1. 0xFF, 0xFF(last) → 0xFF, ovf=1. 0x38 with in_unf=1, 0x38(last) → 0x40, unf=1.
- 16 beats of 0x38, no in_last → 0x58, count=16. Output appears 2 cycles after the 16th beat.
- out_ready low for 5 cycles → in_ready=0 and out_data stable throughout. Release → in_ready=1 the next cycle and a new group accepted.
- rst_n pulsed after 3 beats of a group → all outputs at reset values. A following group 0x38(last) → 0x38, count=1.
